// File: rtl/ttab_event_queue.sv
// Trigger-table event queue: buffers {cp_id, trigger_id} words and raises a level irq
// to the control-plane CPU on an occupancy threshold or an age timeout.
module ttab_event_queue #(
    parameter int unsigned DEPTH_WIDTH   = 4,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic        SYS_CLK,
    input  logic        DETECT_RST,
    input  logic        fifo_wvalid,
    output logic        fifo_wready,
    input  logic [15:0] fifo_wdata,
    input  logic        is_this_table,
    input  logic [14:0] col,
    input  logic [14:0] row,
    input  logic [63:0] wdata,
    input  logic        wen,
    output logic [63:0] rdata,
    output logic        irq
);
    localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0]     FullCount = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0]     CntOne    = 1;
    localparam logic [DEPTH_WIDTH-1:0]   PtrOne    = 1;
    localparam logic [TIMEOUT_WIDTH-1:0] AgeOne    = 1;
    localparam logic [31:0]              AccOne    = 1;

    logic [15:0]              mem_q [DEPTH];
    logic [15:0]              mem_d [DEPTH];
    logic [DEPTH_WIDTH-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_WIDTH:0]     count_q, count_d;
    logic [DEPTH_WIDTH:0]     threshold_q, threshold_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0] age_q, age_d;
    logic [31:0]              accepted_q, accepted_d;
    logic                     irq_en_q, irq_en_d;
    logic                     irq_q, irq_d;

    logic        empty, full, push, pop, reg_we;
    logic [15:0] head_word;

    // Row is meaningless for a single-row table; upper write-data bits carry no field.
    logic unused_bits;
    assign unused_bits = ^{row, wdata[63:TIMEOUT_WIDTH]};

    assign empty       = (count_q == '0);
    assign full        = (count_q == FullCount);
    assign fifo_wready = ~full;
    assign push        = fifo_wvalid & ~full;
    assign reg_we      = wen & is_this_table;
    assign pop         = reg_we & (col == 15'd2) & ~empty;
    assign head_word   = empty ? 16'h0000 : mem_q[rptr_q];
    assign irq         = irq_q;

    always_comb begin
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        threshold_d = threshold_q;
        timeout_d   = timeout_q;
        irq_en_d    = irq_en_q;
        accepted_d  = accepted_q;

        if (push) begin
            mem_d[wptr_q] = fifo_wdata;
            wptr_d        = wptr_q + PtrOne;
            accepted_d    = accepted_q + AccOne;
        end
        if (pop) begin
            rptr_d = rptr_q + PtrOne;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        if (reg_we) begin
            case (col)
                15'd3:   irq_en_d    = wdata[0];
                15'd4:   threshold_d = wdata[DEPTH_WIDTH:0];
                15'd5:   timeout_d   = wdata[TIMEOUT_WIDTH-1:0];
                15'd6:   accepted_d  = '0;
                default: ;
            endcase
        end

        if (pop || empty) begin
            age_d = '0;
        end else if (age_q == '1) begin
            age_d = age_q;
        end else begin
            age_d = age_q + AgeOne;
        end

        irq_d = irq_en_q & ~empty &
                (((threshold_q != '0) && (count_q >= threshold_q)) ||
                 ((timeout_q != '0) && (age_q >= timeout_q)));
    end

    always_comb begin
        rdata = '0;
        case (col)
            15'd0:   rdata = {47'b0, ~empty, head_word};
            15'd1:   rdata = {{(63 - DEPTH_WIDTH){1'b0}}, count_q};
            15'd3:   rdata = {63'b0, irq_en_q};
            15'd4:   rdata = {{(63 - DEPTH_WIDTH){1'b0}}, threshold_q};
            15'd5:   rdata = {{(64 - TIMEOUT_WIDTH){1'b0}}, timeout_q};
            15'd6:   rdata = {32'b0, accepted_q};
            15'd7:   rdata = {63'b0, irq_q};
            default: rdata = '0;
        endcase
    end

    // Storage needs no reset: empty pointers mask stale contents.
    always_ff @(posedge SYS_CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
        if (DETECT_RST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            threshold_q <= CntOne;
            timeout_q   <= '0;
            age_q       <= '0;
            accepted_q  <= '0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            threshold_q <= threshold_d;
            timeout_q   <= timeout_d;
            age_q       <= age_d;
            accepted_q  <= accepted_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_ttab_event_queue.sv
// Bench for ttab_event_queue: directed scenarios plus random traffic checked against a
// queue-based reference model.
module tb_ttab_event_queue;
    logic        SYS_CLK = 1'b0;
    logic        DETECT_RST;
    logic        fifo_wvalid, fifo_wready;
    logic [15:0] fifo_wdata;
    logic        is_this_table;
    logic [14:0] col, row;
    logic [63:0] wdata, rdata;
    logic        wen, irq;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic [15:0] m_age;
    logic [4:0]  m_thr;
    logic [15:0] m_to;
    logic [31:0] m_acc;
    logic        m_irq_en, m_irq;

    ttab_event_queue dut (
        .SYS_CLK       (SYS_CLK),
        .DETECT_RST    (DETECT_RST),
        .fifo_wvalid   (fifo_wvalid),
        .fifo_wready   (fifo_wready),
        .fifo_wdata    (fifo_wdata),
        .is_this_table (is_this_table),
        .col           (col),
        .row           (row),
        .wdata         (wdata),
        .wen           (wen),
        .rdata         (rdata),
        .irq           (irq)
    );

    always #20 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_age = '0; m_thr = 5'd1; m_to = '0; m_acc = '0; m_irq_en = 1'b0; m_irq = 1'b0;
    endtask

    task automatic rd(input logic [14:0] c, output logic [63:0] v);
        col = c;
        #1;
        v = rdata;
    endtask

    task automatic check_all();
        logic [63:0] v;
        logic [63:0] e0;
        e0 = (m_q.size() == 0) ? 64'd0 : {47'b0, 1'b1, m_q[0]};
        chk("wready", {63'b0, fifo_wready}, {63'b0, m_q.size() != 16});
        chk("irq", {63'b0, irq}, {63'b0, m_irq});
        rd(0, v); chk("col0_head", v, e0);
        rd(1, v); chk("col1_count", v, 64'(m_q.size()));
        rd(3, v); chk("col3_irq_en", v, {63'b0, m_irq_en});
        rd(4, v); chk("col4_thr", v, {59'b0, m_thr});
        rd(5, v); chk("col5_timeout", v, {48'b0, m_to});
        rd(6, v); chk("col6_accepted", v, {32'b0, m_acc});
        rd(7, v); chk("col7_irq", v, {63'b0, m_irq});
        col = 0;
    endtask

    // One clock: drive inputs, advance the model by the same rules, then check everything.
    task automatic step(input bit v, input logic [15:0] d, input bit we, input logic [14:0] c,
                        input logic [63:0] wd, input bit sel);
        int          n;
        bit          mempty, push, pop, wr;
        logic        nirq;
        logic [15:0] nage;
        fifo_wvalid = v; fifo_wdata = d; wen = we; col = c; wdata = wd; is_this_table = sel;
        n      = m_q.size();
        mempty = (n == 0);
        push   = v && (n != 16);
        wr     = we && sel;
        pop    = wr && (c == 15'd2) && !mempty;
        nirq   = m_irq_en && !mempty &&
                 (((m_thr != 0) && (n >= int'(m_thr))) || ((m_to != 0) && (m_age >= m_to)));
        nage   = (pop || mempty) ? 16'd0 : ((m_age == 16'hFFFF) ? m_age : m_age + 16'd1);
        @(posedge SYS_CLK);
        #1;
        fifo_wvalid = 1'b0; wen = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(d);
            m_acc = m_acc + 32'd1;
        end
        m_age = nage;
        m_irq = nirq;
        if (wr) begin
            case (c)
                15'd3: m_irq_en = wd[0];
                15'd4: m_thr = wd[4:0];
                15'd5: m_to = wd[15:0];
                15'd6: m_acc = '0;
                default: ;
            endcase
        end
        check_all();
    endtask

    task automatic push_w(input logic [15:0] d); step(1, d, 0, 0, 0, 1); endtask
    task automatic pop_w(); step(0, 0, 1, 2, 0, 1); endtask
    task automatic wr_reg(input logic [14:0] c, input logic [63:0] wd); step(0, 0, 1, c, wd, 1); endtask
    task automatic idle(); step(0, 0, 0, 0, 0, 1); endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset();
        logic [63:0] v;
        @(negedge SYS_CLK);
        DETECT_RST = 1'b1;
        #1;
        chk("rst_irq", {63'b0, irq}, 64'd0);
        chk("rst_wready", {63'b0, fifo_wready}, 64'd1);
        rd(1, v); chk("rst_count", v, 64'd0);
        rd(3, v); chk("rst_irq_en", v, 64'd0);
        rd(4, v); chk("rst_thr", v, 64'd1);
        col = 0;
        model_reset();
        @(posedge SYS_CLK);
        #1;
        DETECT_RST = 1'b0;
    endtask

    initial begin
        logic [63:0] v;
        DETECT_RST = 1'b1; fifo_wvalid = 0; fifo_wdata = 0; is_this_table = 1;
        col = 0; row = 0; wdata = 0; wen = 0;
        model_reset();
        #50;
        DETECT_RST = 1'b0;
        check_all();

        // 1: single push, irq at threshold 1
        wr_reg(3, 1);
        push_w(16'h0A05);
        chk("t1_irq_edge1", {63'b0, irq}, 64'd0);
        idle();
        chk("t1_irq_edge2", {63'b0, irq}, 64'd1);
        rd(0, v); chk("t1_col0", v, 64'h1_0A05);

        // 2: fill, back-pressure, pop while full, drain in order
        mid_reset();
        for (int i = 0; i < 16; i++) push_w(16'(i));
        chk("t2_full_wready", {63'b0, fifo_wready}, 64'd0);
        step(1, 16'h0ABC, 0, 0, 0, 1);
        rd(1, v); chk("t2_held_count", v, 64'd16);
        step(1, 16'h0ABC, 1, 2, 0, 1);
        chk("t2_wready_after_pop", {63'b0, fifo_wready}, 64'd1);
        push_w(16'h0ABC);
        for (int i = 1; i < 17; i++) begin
            rd(0, v);
            chk("t2_drain", v, {47'b0, 1'b1, (i == 16) ? 16'h0ABC : 16'(i)});
            pop_w();
        end
        rd(0, v); chk("t2_drained", v, 64'd0);

        // 3: threshold of four
        mid_reset();
        wr_reg(4, 4); wr_reg(3, 1);
        for (int i = 0; i < 4; i++) push_w(16'h0300 + 16'(i));
        chk("t3_irq_before", {63'b0, irq}, 64'd0);
        idle();
        chk("t3_irq_set", {63'b0, irq}, 64'd1);
        pop_w();
        idle();
        chk("t3_irq_clear", {63'b0, irq}, 64'd0);

        // 4: age timeout of ten
        mid_reset();
        wr_reg(4, 0); wr_reg(5, 10); wr_reg(3, 1);
        push_w(16'h0404);
        for (int i = 1; i <= 10; i++) idle();
        chk("t4_irq_early", {63'b0, irq}, 64'd0);
        idle();
        chk("t4_irq_at_11", {63'b0, irq}, 64'd1);
        pop_w();
        idle();
        chk("t4_irq_fall", {63'b0, irq}, 64'd0);

        // 5: push and pop together with one entry
        mid_reset();
        push_w(16'h0011);
        step(1, 16'h0102, 1, 2, 0, 1);
        rd(1, v); chk("t5_count", v, 64'd1);
        rd(0, v); chk("t5_head", v, 64'h1_0102);
        rd(6, v); chk("t5_accepted", v, 64'd2);

        // 6: pop on empty, then async reset with pending irq
        mid_reset();
        pop_w();
        rd(0, v); chk("t6_empty_col0", v, 64'd0);
        wr_reg(3, 1);
        for (int i = 0; i < 5; i++) push_w(16'h0600 + 16'(i));
        idle();
        chk("t6_irq_pre_reset", {63'b0, irq}, 64'd1);
        mid_reset();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [14:0] c;
            bit          v_in;
            if ($urandom_range(0, 599) == 0) mid_reset();
            v_in = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 8);
            c = (r < 4) ? 15'd2 : (r == 8) ? 15'd9 : 15'(r - 1);
            step(v_in, 16'($urandom), $urandom_range(0, 1) == 1, c,
                 64'($urandom_range(0, 20)), $urandom_range(0, 7) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ttab_event_queue.md
Name: ttab_event_queue

Overview:
- Consumer end of the trigger-table event port.
- Accepts {CP_ID, trigger_id} event words pushed by a trigger table over a valid/ready write interface.
- Buffers the words in a FIFO and raises a level interrupt toward the control-plane CPU, gated by a count threshold or an age timeout.
- Exposes head/pop/count/config through the same col/row table register interface used by the other control-plane tables.

Parameters:
DEPTH_WIDTH, 4, log2 of FIFO depth
DEPTH, 2**DEPTH_WIDTH, number of 16-bit event entries
TIMEOUT_WIDTH, 16, width of age timer and timeout register

Ports:
SYS_CLK  in  1  clock
DETECT_RST  in  1  reset
fifo_wvalid  in  1  event word valid from trigger table
fifo_wready  out  1  queue can accept a word
fifo_wdata  in  16  event word {cp_id[15:8], trigger_id[7:0]}
is_this_table  in  1  register access targets this block
col  in  15  register column select
row  in  15  row select; ignored, single-row table
wdata  in  64  register write data
wen  in  1  register write strobe
rdata  out  64  combinational register read data
irq  out  1  level interrupt to CPU

Behaviour:
- Reset: DETECT_RST, asynchronous, active-high; clock SYS_CLK. All state below is reset by DETECT_RST.
- Reset values: FIFO empty, count=0, fifo_wready=1, irq=0, irq_en=0, threshold=1, timeout=0, age=0, accepted=0.
- FIFO storage: circular buffer of DEPTH entries with wptr/rptr of DEPTH_WIDTH bits each, wrapping naturally.
- FIFO occupancy: count is DEPTH_WIDTH+1 bits; full when count==DEPTH; empty when count==0.
- fifo_wready = ~full, combinational from registered count.
- Push: occurs when fifo_wvalid & fifo_wready at a rising edge. The word is written at wptr, wptr increments, and the word is visible at the head on the next cycle if the FIFO was empty.
- Register write (wen & is_this_table), by col:
  - 2: pop when not empty, wdata ignored; pop on empty is a no-op.
  - 3: irq_en <= wdata[0].
  - 4: threshold <= wdata[DEPTH_WIDTH:0].
  - 5: timeout <= wdata[TIMEOUT_WIDTH-1:0].
  - 6: accepted <= 0.
  - Other cols are ignored.
- Register read, combinational from col, without side effects:
  - 0: {47'b0, ~empty, head_word}; head_word is 0 when empty.
  - 1: zero-extended count.
  - 3: irq_en.
  - 4: threshold.
  - 5: timeout.
  - 6: {32'b0, accepted}.
  - 7: {63'b0, irq}.
  - Others: 0.
- Simultaneous push and pop: both take effect; count is unchanged; rptr and wptr both advance.
- Push and pop while count==1: the new word becomes the head next cycle.
- When full, no push occurs, so a pop while full only frees a slot. fifo_wready rises the cycle after the pop.
- accepted: 32-bit counter of accepted pushes; wraps at 2^32. A clear write in the same cycle as a push leaves the result at 0.
- age timer:
  - Cleared to 0 on any pop, or whenever the FIFO is empty.
  - Otherwise increments each cycle while non-empty; saturates at all-ones.
  - A push into a non-empty FIFO does not clear age.
- irq, registered:
  - irq <= irq_en & ~empty & ((threshold!=0 & count>=threshold) | (timeout!=0 & age>=timeout)).
  - Evaluated on the registered count/age, so irq follows its condition with one cycle of latency.
  - Deasserts one cycle after the condition drops, e.g. popping below threshold or age cleared by a pop.
  - threshold=0 and timeout=0 together disable irq.
- Reset mid-operation: FIFO contents are discarded, pointers return to 0, irq drops immediately and asynchronously. In-flight register writes in that cycle are lost.

Test Plan:
1. Reset, then push 0x0A05 → col1 reads 1. With irq_en=1, threshold=1: irq=1 on the 2nd edge after the push. col0 reads 0x1_0A05.
2. Push 16 words 0x0000..0x000F → fifo_wready=0 after the 16th. A 17th valid word is held off, and the writer's value is still pending. Pop once → fifo_wready=1 next cycle. The held word is accepted and becomes the tail; pops return 0x0000..0x000F then that word.
3. threshold=4, timeout=0, irq_en=1: push 3 words → irq stays 0. 4th push → irq=1. One pop → irq=0 one cycle later.
4. threshold=0, timeout=10, irq_en=1: single push, no pops → irq rises exactly 11 cycles after the word becomes visible. A pop clears age, and irq falls one cycle later.
5. With count=1, drive a push (0x0102) and a col2 pop in the same cycle → count stays 1, head=0x0102, accepted increments by 1.
6. Pop on an empty FIFO → count stays 0, col0 reads 0. Assert DETECT_RST with 5 entries and irq=1 → irq and count are 0 immediately, fifo_wready=1, irq_en=0.
